// File: rtl/qoa_slice_unpacker.sv
// Purpose: byte-serial QOA slice unpacker; 8 big-endian bytes in, scale factor + 20 residual indices out.
// Latency: out_valid rises 1 cycle after the 8th byte; 28 cycles/slice, or 20 with QOA_UNPACK_PREFETCH_EN defined.
// Backpressure: in_ready low while emitting (unless prefetching); outputs hold stable while out_ready is low.
module qoa_slice_unpacker #(
    parameter int RESIDUALS = 20,
    parameter int BYTES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_sf,
    output logic [2:0] out_idx,
    output logic [4:0] out_pos,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [4:0] LAST_POS = 5'(RESIDUALS - 1);
    localparam logic [3:0] FULL     = 4'(BYTES);

    typedef enum logic {LOAD, EMIT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] slice_q;
    logic [3:0]  byte_cnt;
    logic [4:0]  res_cnt;
    logic        in_fire;
    logic        out_fire;
    logic        last_fire;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_fire = out_fire && (res_cnt == LAST_POS);

    // The scale factor stays parked in the top nibble; residuals shift up under it.
    assign out_sf   = slice_q[63:60];
    assign out_idx  = slice_q[59:57];
    assign out_pos  = res_cnt;
    assign out_last = (res_cnt == LAST_POS);

`ifdef QOA_UNPACK_PREFETCH_EN
    logic [63:0] shadow_q;
    logic [3:0]  shadow_cnt;
    logic [63:0] shadow_nxt;
    logic [3:0]  shadow_cnt_nxt;
    logic        shadow_fire;

    // Shadow contents including a byte landing in the same cycle as the last residual.
    assign shadow_fire    = in_fire && (state == EMIT);
    assign shadow_nxt     = shadow_fire ? {shadow_q[55:0], in_data} : shadow_q;
    assign shadow_cnt_nxt = shadow_fire ? shadow_cnt + 4'd1 : shadow_cnt;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; flush masks both handshakes and forces LOAD.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            LOAD: begin
                in_ready = !flush && !rst;
                if (in_valid && (byte_cnt == FULL - 4'd1)) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = !flush;
`ifdef QOA_UNPACK_PREFETCH_EN
                in_ready = !flush && !rst && (shadow_cnt < FULL);
                if (out_ready && (res_cnt == LAST_POS)) begin
                    if ((shadow_cnt == FULL) ||
                        ((shadow_cnt == FULL - 4'd1) && in_valid)) begin
                        state_nxt = EMIT;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
`else
                if (out_ready && (res_cnt == LAST_POS)) begin
                    state_nxt = LOAD;
                end
`endif
            end
            default: state_nxt = LOAD;
        endcase
        if (flush) begin
            state_nxt = LOAD;
        end
    end

    // Slice register, byte count and residual count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            slice_q  <= '0;
            byte_cnt <= '0;
            res_cnt  <= '0;
`ifdef QOA_UNPACK_PREFETCH_EN
            shadow_q   <= '0;
            shadow_cnt <= '0;
`endif
        end else begin
            if ((state == LOAD) && in_fire) begin
                slice_q  <= {slice_q[55:0], in_data};
                byte_cnt <= (byte_cnt == FULL - 4'd1) ? 4'd0 : byte_cnt + 4'd1;
            end
            if (out_fire) begin
                if (last_fire) begin
                    res_cnt <= '0;
                end else begin
                    res_cnt        <= res_cnt + 5'd1;
                    slice_q[59:0]  <= {slice_q[56:0], 3'b000};
                end
            end
`ifdef QOA_UNPACK_PREFETCH_EN
            if (last_fire) begin
                // A full shadow becomes the next slice; a partial one resumes loading.
                slice_q    <= shadow_nxt;
                byte_cnt   <= (shadow_cnt_nxt == FULL) ? 4'd0 : shadow_cnt_nxt;
                shadow_q   <= '0;
                shadow_cnt <= '0;
            end else if (shadow_fire) begin
                shadow_q   <= shadow_nxt;
                shadow_cnt <= shadow_cnt_nxt;
            end
`endif
        end
    end

endmodule

// File: tb/tb_qoa_slice_unpacker.sv
// Self-checking bench for qoa_slice_unpacker: directed scenarios, a vector table and random slices.
// Expected residuals come from slice arithmetic; stalls are checked for output stability.
// Back-to-back timing expectation depends on QOA_UNPACK_PREFETCH_EN.
module tb_qoa_slice_unpacker;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_sf;
    logic [2:0] out_idx;
    logic [4:0] out_pos;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;

    always #5 clk = ~clk;

    qoa_slice_unpacker dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sf    (out_sf),
        .out_idx   (out_idx),
        .out_pos   (out_pos),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [3:0] sf;
        logic [2:0] idx;
        logic [4:0] pos;
        logic       last;
    } res_t;

    typedef struct {
        logic [63:0] slice;
        logic [3:0]  sf;
        logic [2:0]  idx0;
        logic [2:0]  idx19;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] byte_q[$];
    res_t       exp_q[$];
    logic [2:0] got_idx[20];
    logic [3:0] got_sf[20];
    int         last_byte_cyc;
    int         first_valid_cyc;
    int         b2b_gap;
    vec_t       vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: byte order and residual positions from the slice bit layout.
    function automatic void add_slice(input logic [63:0] s);
        res_t r;
        for (int b = 0; b < 8; b++) begin
            byte_q.push_back(8'((s >> (56 - 8 * b)) & 64'hFF));
        end
        for (int i = 0; i < 20; i++) begin
            r.sf   = 4'(s >> 60);
            r.idx  = 3'((s >> (57 - 3 * i)) & 64'h7);
            r.pos  = 5'(i);
            r.last = (i == 19);
            exp_q.push_back(r);
        end
    endfunction

    // Drives queued bytes, consumes residuals, compares against the model queue.
    // Called and returns at posedge+1.
    task automatic run(input int gap_pct, input int bp_pct, input int stall_pos, input int stall_idx);
        int   budget = 3000;
        int   t = 0;
        int   bytes_acc = 0;
        int   t19 = 0;
        bit   seen19 = 0;
        bit   acc;
        bit   stall_done = 0;
        int   stall_left = 0;
        bit   stalling;
        bit   prev_hold = 0;
        res_t held = '0;
        res_t e;
        first_valid_cyc = -1;
        last_byte_cyc   = -1;
        b2b_gap         = -1;
        for (int i = 0; i < 20; i++) begin
            got_idx[i] = 'x;
            got_sf[i]  = 'x;
        end
        while ((byte_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            budget--;
            in_valid = (byte_q.size() > 0) && ($urandom_range(99) >= gap_pct);
            in_data  = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
            stalling = 0;
            if (stall_left == 0 && !stall_done && stall_pos >= 0 && out_valid &&
                out_pos == 5'(stall_pos)) begin
                stall_left = 5;
                stall_done = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                stalling = 1;
            end else begin
                out_ready = ($urandom_range(99) >= bp_pct);
            end
            @(negedge clk);
            if (stalling) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_pos", out_pos, 64'(stall_pos));
                chk("stall_idx", out_idx, 64'(stall_idx));
            end
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_out", {out_sf, out_idx, out_pos, out_last}, held);
            end
            acc = in_valid && in_ready;
            if (acc && bytes_acc == 7) last_byte_cyc = t;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = t;
            if (out_valid && seen19 && b2b_gap < 0 && out_pos == 5'd0) b2b_gap = t - t19;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got residual pos %0d expected none", out_pos);
                end else begin
                    e = exp_q.pop_front();
                    chk("residual", {out_sf, out_idx, out_pos, out_last}, e);
                    if (out_pos < 5'd20) begin
                        got_idx[out_pos] = out_idx;
                        got_sf[out_pos]  = out_sf;
                    end
                    if (out_pos == 5'd19 && !seen19) begin
                        t19    = t;
                        seen19 = 1;
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            held      = {out_sf, out_idx, out_pos, out_last};
            @(posedge clk);
            #1;
            if (acc) begin
                void'(byte_q.pop_front());
                bytes_acc++;
            end
            t++;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d bytes %0d residuals pending expected 0", byte_q.size(), exp_q.size());
            byte_q.delete();
            exp_q.delete();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    // The reference slice A053977053977053 decodes to sf A and indices i mod 8.
    task automatic check_ref_seq(input string tag);
        for (int i = 0; i < 20; i++) begin
            chk({tag, "_idx"}, got_idx[i], 64'(i % 8));
            chk({tag, "_sf"}, got_sf[i], 64'hA);
        end
    endtask

    initial begin
        vecs[0] = '{64'hA053977053977053, 4'hA, 3'd0, 3'd3};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 4'hF, 3'd7, 3'd7};
        vecs[2] = '{64'h0000000000000000, 4'h0, 3'd0, 3'd0};
        vecs[3] = '{64'h1E00000000000000, 4'h1, 3'd7, 3'd0};
        vecs[4] = '{64'h0000000000000005, 4'h0, 3'd0, 3'd5};
        vecs[5] = '{64'h5200000000000002, 4'h5, 3'd1, 3'd2};

        // Reset with a byte offered throughout.
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sf", out_sf, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_pos", out_pos, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk);
        #1;

        // Reference slice, continuous valid.
        add_slice(64'hA053977053977053);
        run(0, 0, -1, 0);
        check_ref_seq("ref");
        chk("ref_latency", 64'(first_valid_cyc - last_byte_cyc), 1);
        @(negedge clk);
        chk("ref_end_in_ready", in_ready, 1);
        chk("ref_end_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Stall at out_pos 7 for 5 cycles.
        add_slice(64'hA053977053977053);
        run(0, 0, 7, 7);
        check_ref_seq("stall");

        // Partial slice aborted by flush.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pre_flush_in_ready", in_ready, 1);
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        add_slice(64'hA053977053977053);
        run(0, 0, -1, 0);
        check_ref_seq("flush");

        // Gapped input.
        add_slice(64'hA053977053977053);
        run(50, 0, -1, 0);
        check_ref_seq("gap");

        // Vector table with light gaps and backpressure.
        for (int v = 0; v < 6; v++) begin
            add_slice(vecs[v].slice);
            run(20, 20, -1, 0);
            chk("vec_sf", got_sf[0], vecs[v].sf);
            chk("vec_sf19", got_sf[19], vecs[v].sf);
            chk("vec_idx0", got_idx[0], vecs[v].idx0);
            chk("vec_idx19", got_idx[19], vecs[v].idx19);
        end

        // Random slices streamed together.
        for (int s = 0; s < 8; s++) begin
            add_slice({$urandom, $urandom});
        end
        run(30, 30, -1, 0);

        // Back-to-back slices, no gaps.
        add_slice(64'hA053977053977053);
        add_slice(64'h3C00000000000001);
        run(0, 0, -1, 0);
`ifdef QOA_UNPACK_PREFETCH_EN
        chk("b2b_gap", 64'(b2b_gap), 1);
`else
        chk("b2b_gap_ge9", 64'(b2b_gap >= 9), 1);
`endif
        chk("b2b_sf2", got_sf[19], 4'h3);
        chk("b2b_idx19", got_idx[19], 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
